can_fault_confine: RTL and testbench
====================================

Name: can_fault_confine

Overview:
Parametrised fault-confinement unit for the Basic CAN controller. It is the successor to the fixed 8-bit error management logic. It maintains the transmit and receive error counters (TEC/REC) and derives error-active, error-passive and bus-off status. It adds a programmable warning limit, an explicit bus-off recovery sequence counter, test-mode counter writes and status-change event pulses. It sits between the transceiver control logic (error events) and the interface/register logic (status, counters, interrupts).

Parameters:
CNT_W, 8, visible counter width. Passive limit P = 2^(CNT_W-1); bus-off limit B = 2^CNT_W.
RECOV_N, 128, number of 11-recessive-bit sequences required to leave bus-off.
EWL_RST, 96, warning limit value loaded when ewl_wr is asserted with ewl_wdata=0 (guard value).

Ports:
clk  in  1  system clock
reset  in  1  HW/SW reset
bit_en  in  1  bit-time clock enable from bit timing logic
err  in  1  error detected this bit
ko_error  in  3  kind of error, valid with err
transvalid  in  1  frame transmitted successfully
rec_ack  in  1  frame received successfully
ebf  in  1  11 consecutive recessive bits seen
init_mode  in  1  controller in reset/initialisation mode
cnt_wr  in  1  test write strobe for counters, single clk
tec_wdata  in  CNT_W  TEC write value
rec_wdata  in  CNT_W  REC write value
ewl_wr  in  1  warning-limit write strobe
ewl_wdata  in  CNT_W  warning-limit write value
tec  out  CNT_W  TEC[CNT_W-1:0]
rec  out  CNT_W  REC
ewl  out  CNT_W  current warning limit
error_active  out  1  node error-active
error_passive  out  1  node error-passive
busoff  out  1  node bus-off
warn  out  1  warning status
recov_cnt  out  log2(RECOV_N)+1  recovery sequences counted
irq_warn  out  1  one-clk pulse on warn change
irq_state  out  1  one-clk pulse on active/passive/bus-off change

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset: tec=0, rec=0, internal TEC bit CNT_W=0, ewl=EWL_RST, recov_cnt=0, state ACTIVE, irq_*=0, warn=0.
- Internal TEC is CNT_W+1 bits wide. REC saturates at 2^CNT_W-1.
- State machine:
  - ACTIVE: TEC<P and REC<P.
  - PASSIVE: TEC>=P or REC>=P, and TEC<B.
  - BUSOFF: TEC>=B.
  - Outputs are decoded from state. Exactly one of error_active/error_passive/busoff is high.
- Event processing happens only when bit_en=1. Priority: err > transvalid > rec_ack. Lower-priority events in the same cycle are ignored.
- err in ACTIVE/PASSIVE, by ko_error:
  - 1: REC+1.
  - 2: REC+8.
  - 3: TEC+8 in ACTIVE only; ignored in PASSIVE (ack error while passive).
  - 4: TEC+8.
  - 0, 5-7: no change.
  - REC increments saturate.
- transvalid: TEC-1 if nonzero.
- rec_ack: if REC>=P then REC=P-1 (never below; REC=P gives P-1); else if REC>0 then REC-1.
- Counter events are ignored in BUSOFF.
- Entering BUSOFF (TEC reaches >=B): next clk sets REC=0 and recov_cnt=0. tec output shows the low CNT_W bits.
- BUSOFF recovery: each bit_en & ebf & !init_mode increments recov_cnt. When recov_cnt reaches RECOV_N: TEC=0, REC=0, recov_cnt=0, state ACTIVE, same clk. While init_mode=1 in BUSOFF, recov_cnt holds.
- warn = (TEC>=ewl) | (REC>=ewl) | busoff, unsigned compare on CNT_W bits plus busoff.
- ewl_wr: ewl=ewl_wdata, or EWL_RST if ewl_wdata=0. Accepted only in init_mode.
- cnt_wr: accepted only in init_mode, and takes priority over bit_en events.
  - Loads TEC={0,tec_wdata} and REC=rec_wdata.
  - If in BUSOFF, cnt_wr with tec_wdata<P leaves bus-off immediately; recov_cnt=0.
- irq_warn: one-clk pulse when registered warn differs from previous clk.
- irq_state: one-clk pulse when state differs from previous clk.
- Reset mid-recovery aborts it; all values return to reset state.

Optional Feature:
Macro FC_STATUS_IRQ_EN.
- Defined: irq_warn/irq_state generated as above.
- Undefined: both tied 0; previous-state registers not synthesised.

Test Plan:
- 16 err ko=4 with bit_en -> tec=128, error_passive=1; irq_state pulses once at the 128 transition.
- rec=130 (cnt_wr in init_mode), then rec_ack -> rec=127; second rec_ack -> 126; error_active=1.
- In PASSIVE, err ko=3 -> tec unchanged; err ko=4 -> tec+8. err and transvalid in the same bit_en -> only the err applied.
- Drive tec to 256 -> busoff=1, rec=0, warn=1. 127 ebf pulses -> still busoff, recov_cnt=127. 128th ebf -> tec=0, rec=0, error_active=1. With init_mode=1, ebf does not count.
- ewl_wr 10 in init_mode, then 2 err ko=1 steps to rec=10 -> warn rises at rec=10; irq_warn pulses. ewl_wr 0 -> ewl=96.
- Reset asserted asynchronously at recov_cnt=50 -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/can_fault_confine.sv
// CAN fault confinement: TEC/REC counters, active/passive/bus-off state, warning limit,
// bus-off recovery counting. Optional status-change pulses under `FC_STATUS_IRQ_EN.
module can_fault_confine #(
  parameter int CNT_W   = 8,
  parameter int RECOV_N = 128,
  parameter int EWL_RST = 96,
  localparam int RC_W   = $clog2(RECOV_N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             err,
  input  logic [2:0]       ko_error,
  input  logic             transvalid,
  input  logic             rec_ack,
  input  logic             ebf,
  input  logic             init_mode,
  input  logic             cnt_wr,
  input  logic [CNT_W-1:0] tec_wdata,
  input  logic [CNT_W-1:0] rec_wdata,
  input  logic             ewl_wr,
  input  logic [CNT_W-1:0] ewl_wdata,
  output logic [CNT_W-1:0] tec,
  output logic [CNT_W-1:0] rec,
  output logic [CNT_W-1:0] ewl,
  output logic             error_active,
  output logic             error_passive,
  output logic             busoff,
  output logic             warn,
  output logic [RC_W-1:0]  recov_cnt,
  output logic             irq_warn,
  output logic             irq_state
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_PASSIVE, ST_BUSOFF} fc_state_e;

  // TEC carries one extra bit so the bus-off threshold is representable.
  typedef struct packed {
    logic [CNT_W:0]   tec;
    logic [CNT_W-1:0] rec;
    logic [RC_W-1:0]  recov;
  } cnt_t;

  localparam logic [CNT_W:0]   TEC_P    = (CNT_W+1)'(2**(CNT_W-1));
  localparam logic [CNT_W:0]   TEC_B    = (CNT_W+1)'(2**CNT_W);
  localparam logic [CNT_W:0]   TEC_STEP = (CNT_W+1)'(8);
  localparam logic [CNT_W:0]   TEC_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   REC_INC1 = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   REC_INC8 = (CNT_W+1)'(8);
  localparam logic [CNT_W-1:0] REC_P    = CNT_W'(2**(CNT_W-1));
  localparam logic [CNT_W-1:0] REC_PM1  = CNT_W'(2**(CNT_W-1) - 1);
  localparam logic [CNT_W-1:0] REC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] REC_MAX  = '1;
  localparam logic [CNT_W-1:0] EWL_DEF  = CNT_W'(EWL_RST);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RECOV_N);

  cnt_t       cnt_q, cnt_d;
  fc_state_e  state_q, state_d;
  logic [CNT_W-1:0] ewl_q, ewl_d;
  logic       warn_q, warn_d;
  logic       boff_entry_q, boff_entry_d;
  logic       cnt_wr_ok;
  logic [RC_W-1:0] recov_inc;

  function automatic logic [CNT_W-1:0] rec_add(input logic [CNT_W-1:0] r,
                                               input logic [CNT_W:0]   amt);
    logic [CNT_W:0] s;
    s = {1'b0, r} + amt;
    return (s > {1'b0, REC_MAX}) ? REC_MAX : s[CNT_W-1:0];
  endfunction

  function automatic fc_state_e classify(input logic [CNT_W:0]   t,
                                         input logic [CNT_W-1:0] r);
    if (t >= TEC_B) return ST_BUSOFF;
    if (t >= TEC_P || r >= REC_P) return ST_PASSIVE;
    return ST_ACTIVE;
  endfunction

  assign cnt_wr_ok = cnt_wr & init_mode;
  assign recov_inc = cnt_q.recov + RC_ONE;

  always_comb begin
    cnt_d   = cnt_q;
    ewl_d   = ewl_q;
    state_d = state_q;

    if (ewl_wr && init_mode)
      ewl_d = (ewl_wdata == '0) ? EWL_DEF : ewl_wdata;

    if (cnt_wr_ok) begin
      cnt_d.tec = {1'b0, tec_wdata};
      cnt_d.rec = rec_wdata;
      if (state_q != ST_BUSOFF) begin
        state_d = classify(cnt_d.tec, cnt_d.rec);
      end else if ({1'b0, tec_wdata} < TEC_P) begin
        cnt_d.recov = '0;
        state_d     = classify(cnt_d.tec, cnt_d.rec);
      end
    end else if (state_q == ST_BUSOFF) begin
      // First bus-off clock clears REC; counter events stay frozen until recovery.
      if (boff_entry_q) begin
        cnt_d.rec   = '0;
        cnt_d.recov = '0;
      end else if (bit_en && ebf && !init_mode) begin
        if (recov_inc == RC_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end else begin
          cnt_d.recov = recov_inc;
        end
      end
    end else begin
      if (bit_en) begin
        if (err) begin
          case (ko_error)
            3'd1: cnt_d.rec = rec_add(cnt_q.rec, REC_INC1);
            3'd2: cnt_d.rec = rec_add(cnt_q.rec, REC_INC8);
            3'd3: if (state_q == ST_ACTIVE) cnt_d.tec = cnt_q.tec + TEC_STEP;
            3'd4: cnt_d.tec = cnt_q.tec + TEC_STEP;
            default: ;
          endcase
        end else if (transvalid) begin
          if (cnt_q.tec != '0) cnt_d.tec = cnt_q.tec - TEC_ONE;
        end else if (rec_ack) begin
          if (cnt_q.rec >= REC_P) cnt_d.rec = REC_PM1;
          else if (cnt_q.rec != '0) cnt_d.rec = cnt_q.rec - REC_ONE;
        end
      end
      state_d = classify(cnt_d.tec, cnt_d.rec);
    end

    boff_entry_d = (state_d == ST_BUSOFF) && (state_q != ST_BUSOFF);
    warn_d = (cnt_d.tec[CNT_W-1:0] >= ewl_d) | (cnt_d.rec >= ewl_d) | (state_d == ST_BUSOFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      ewl_q        <= EWL_DEF;
      state_q      <= ST_ACTIVE;
      warn_q       <= 1'b0;
      boff_entry_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ewl_q        <= ewl_d;
      state_q      <= state_d;
      warn_q       <= warn_d;
      boff_entry_q <= boff_entry_d;
    end
  end

  assign tec           = cnt_q.tec[CNT_W-1:0];
  assign rec           = cnt_q.rec;
  assign ewl           = ewl_q;
  assign recov_cnt     = cnt_q.recov;
  assign warn          = warn_q;
  assign error_active  = (state_q == ST_ACTIVE);
  assign error_passive = (state_q == ST_PASSIVE);
  assign busoff        = (state_q == ST_BUSOFF);

`ifdef FC_STATUS_IRQ_EN
  logic      warn_prev_q;
  fc_state_e state_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warn_prev_q  <= 1'b0;
      state_prev_q <= ST_ACTIVE;
    end else begin
      warn_prev_q  <= warn_q;
      state_prev_q <= state_q;
    end
  end

  assign irq_warn  = warn_q ^ warn_prev_q;
  assign irq_state = (state_q != state_prev_q);
`else
  assign irq_warn  = 1'b0;
  assign irq_state = 1'b0;
`endif

endmodule

// File: tb/tb_can_fault_confine.sv
// Bench for can_fault_confine: directed scenarios plus randomized traffic
// checked against an arithmetic model of the confinement rules.
module tb_can_fault_confine;

`ifdef FC_STATUS_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, bit_en, err, transvalid, rec_ack, ebf, init_mode, cnt_wr, ewl_wr;
  logic [2:0] ko_error;
  logic [7:0] tec_wdata, rec_wdata, ewl_wdata;
  logic [7:0] tec, rec, ewl, recov_cnt;
  logic       error_active, error_passive, busoff, warn, irq_warn, irq_state;

  int n_chk = 0;
  int n_fail = 0;

  // reference model
  int m_tec, m_rec, m_ewl, m_recov, m_st;
  bit m_boff, m_pend, m_warn, m_irq_w, m_irq_s;

  can_fault_confine dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .err(err), .ko_error(ko_error),
    .transvalid(transvalid), .rec_ack(rec_ack), .ebf(ebf), .init_mode(init_mode),
    .cnt_wr(cnt_wr), .tec_wdata(tec_wdata), .rec_wdata(rec_wdata), .ewl_wr(ewl_wr),
    .ewl_wdata(ewl_wdata), .tec(tec), .rec(rec), .ewl(ewl), .error_active(error_active),
    .error_passive(error_passive), .busoff(busoff), .warn(warn), .recov_cnt(recov_cnt),
    .irq_warn(irq_warn), .irq_state(irq_state)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bit_en = 0; err = 0; ko_error = 0; transvalid = 0; rec_ack = 0; ebf = 0;
    init_mode = 0; cnt_wr = 0; tec_wdata = 0; rec_wdata = 0; ewl_wr = 0; ewl_wdata = 0;
  endtask

  task automatic model_reset();
    m_tec = 0; m_rec = 0; m_ewl = 96; m_recov = 0; m_st = 0;
    m_boff = 0; m_pend = 0; m_warn = 0; m_irq_w = 0; m_irq_s = 0;
  endtask

  task automatic model_step();
    int old_st;
    bit old_w;
    old_st = m_st; old_w = m_warn;
    if (ewl_wr && init_mode) m_ewl = (ewl_wdata == 0) ? 96 : int'(ewl_wdata);
    if (cnt_wr && init_mode) begin
      m_tec = tec_wdata; m_rec = rec_wdata; m_pend = 0;
      if (m_boff && tec_wdata < 128) begin m_boff = 0; m_recov = 0; end
    end else if (m_boff) begin
      if (m_pend) begin
        m_rec = 0; m_recov = 0; m_pend = 0;
      end else if (bit_en && ebf && !init_mode) begin
        m_recov++;
        if (m_recov == 128) begin m_tec = 0; m_rec = 0; m_recov = 0; m_boff = 0; end
      end
    end else if (bit_en) begin
      if (err) begin
        if (ko_error == 1) m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
        if (ko_error == 2) m_rec = (m_rec + 8 > 255) ? 255 : m_rec + 8;
        if (ko_error == 3 && old_st == 0) m_tec += 8;
        if (ko_error == 4) m_tec += 8;
      end else if (transvalid) begin
        if (m_tec > 0) m_tec--;
      end else if (rec_ack) begin
        if (m_rec >= 128) m_rec = 127;
        else if (m_rec > 0) m_rec--;
      end
      if (m_tec >= 256) begin m_boff = 1; m_pend = 1; end
    end
    m_st = m_boff ? 2 : ((m_tec >= 128 || m_rec >= 128) ? 1 : 0);
    m_warn = ((m_tec % 256) >= m_ewl) || (m_rec >= m_ewl) || m_boff;
    m_irq_w = IRQ_ON && (m_warn != old_w);
    m_irq_s = IRQ_ON && (m_st != old_st);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    n_chk++; if (tec !== 8'd0) begin n_fail++; $display("FAIL reset.tec got %0d want 0", tec); end
    n_chk++; if (rec !== 8'd0) begin n_fail++; $display("FAIL reset.rec got %0d want 0", rec); end
    n_chk++; if (ewl !== 8'd96) begin n_fail++; $display("FAIL reset.ewl got %0d want 96", ewl); end
    n_chk++; if ({error_active, error_passive, busoff} !== 3'b100) begin
      n_fail++; $display("FAIL reset.state got %b want 100", {error_active, error_passive, busoff}); end
    n_chk++; if ({warn, irq_warn, irq_state} !== 3'b000) begin
      n_fail++; $display("FAIL reset.flags got %b want 000", {warn, irq_warn, irq_state}); end
    n_chk++; if (recov_cnt !== 8'd0) begin n_fail++; $display("FAIL reset.recov got %0d want 0", recov_cnt); end
    reset = 0;
    model_reset();
  endtask

  task automatic test_tec_passive();
    int pulses;
    pulses = 0;
    apply_reset();
    bit_en = 1; err = 1; ko_error = 4;
    for (int i = 0; i < 16; i++) begin
      step();
      if (irq_state) pulses++;
    end
    n_chk++; if (tec !== 8'd128) begin n_fail++; $display("FAIL tec_passive.tec got %0d want 128", tec); end
    n_chk++; if ({error_active, error_passive, busoff} !== 3'b010) begin
      n_fail++; $display("FAIL tec_passive.state got %b want 010", {error_active, error_passive, busoff}); end
    n_chk++; if (pulses !== int'(IRQ_ON)) begin
      n_fail++; $display("FAIL tec_passive.irq_pulses got %0d want %0d", pulses, int'(IRQ_ON)); end
    idle();
    step();
    n_chk++; if (irq_state !== 1'b0) begin n_fail++; $display("FAIL tec_passive.irq_clear got %b want 0", irq_state); end
  endtask

  task automatic test_rec_ack();
    apply_reset();
    init_mode = 1; cnt_wr = 1; rec_wdata = 130;
    step();
    idle();
    n_chk++; if (rec !== 8'd130 || error_passive !== 1'b1) begin
      n_fail++; $display("FAIL rec_ack.load got rec=%0d passive=%b want 130/1", rec, error_passive); end
    bit_en = 1; rec_ack = 1;
    step();
    n_chk++; if (rec !== 8'd127) begin n_fail++; $display("FAIL rec_ack.first got %0d want 127", rec); end
    step();
    n_chk++; if (rec !== 8'd126) begin n_fail++; $display("FAIL rec_ack.second got %0d want 126", rec); end
    n_chk++; if (error_active !== 1'b1) begin n_fail++; $display("FAIL rec_ack.active got %b want 1", error_active); end
  endtask

  task automatic test_passive_ack();
    apply_reset();
    bit_en = 1; err = 1; ko_error = 3;
    step();
    n_chk++; if (tec !== 8'd8) begin n_fail++; $display("FAIL passive_ack.active_ko3 got %0d want 8", tec); end
    idle();
    init_mode = 1; cnt_wr = 1; tec_wdata = 130;
    step();
    idle();
    bit_en = 1; err = 1; ko_error = 3;
    step();
    n_chk++; if (tec !== 8'd130) begin n_fail++; $display("FAIL passive_ack.ko3 got %0d want 130", tec); end
    ko_error = 4;
    step();
    n_chk++; if (tec !== 8'd138) begin n_fail++; $display("FAIL passive_ack.ko4 got %0d want 138", tec); end
    transvalid = 1;
    step();
    n_chk++; if (tec !== 8'd146) begin n_fail++; $display("FAIL passive_ack.err_prio got %0d want 146", tec); end
    err = 0;
    step();
    n_chk++; if (tec !== 8'd145) begin n_fail++; $display("FAIL passive_ack.tv got %0d want 145", tec); end
    bit_en = 0; err = 1; transvalid = 0;
    step();
    n_chk++; if (tec !== 8'd145) begin n_fail++; $display("FAIL passive_ack.no_bit_en got %0d want 145", tec); end
  endtask

  task automatic test_busoff();
    apply_reset();
    init_mode = 1; cnt_wr = 1; tec_wdata = 248; rec_wdata = 20;
    step();
    idle();
    bit_en = 1; err = 1; ko_error = 4;
    step();
    n_chk++; if ({busoff, warn, tec} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL busoff.enter got busoff=%b warn=%b tec=%0d want 1/1/0", busoff, warn, tec); end
    idle();
    step();
    n_chk++; if (rec !== 8'd0) begin n_fail++; $display("FAIL busoff.rec_clear got %0d want 0", rec); end
    init_mode = 1; bit_en = 1; ebf = 1;
    repeat (5) step();
    n_chk++; if (recov_cnt !== 8'd0) begin n_fail++; $display("FAIL busoff.init_hold got %0d want 0", recov_cnt); end
    init_mode = 0; err = 1;
    for (int i = 0; i < 127; i++) begin
      ko_error = 3'($urandom_range(7));
      step();
    end
    n_chk++; if ({busoff, recov_cnt, tec} !== {1'b1, 8'd127, 8'd0}) begin
      n_fail++; $display("FAIL busoff.count got busoff=%b recov=%0d tec=%0d want 1/127/0", busoff, recov_cnt, tec); end
    step();
    n_chk++; if ({error_active, tec, rec, recov_cnt} !== {1'b1, 8'd0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL busoff.recover got act=%b tec=%0d rec=%0d recov=%0d want 1/0/0/0",
                         error_active, tec, rec, recov_cnt); end
    idle();
    bit_en = 1; err = 1; ko_error = 4;
    step();
    n_chk++; if ({error_active, tec} !== {1'b1, 8'd8}) begin
      n_fail++; $display("FAIL busoff.post got act=%b tec=%0d want 1/8", error_active, tec); end
  endtask

  task automatic test_warn();
    apply_reset();
    init_mode = 1; ewl_wr = 1; ewl_wdata = 10; cnt_wr = 1; rec_wdata = 8;
    step();
    idle();
    n_chk++; if ({ewl, warn} !== {8'd10, 1'b0}) begin
      n_fail++; $display("FAIL warn.ewl got ewl=%0d warn=%b want 10/0", ewl, warn); end
    bit_en = 1; err = 1; ko_error = 1;
    step();
    n_chk++; if ({rec, warn} !== {8'd9, 1'b0}) begin
      n_fail++; $display("FAIL warn.below got rec=%0d warn=%b want 9/0", rec, warn); end
    step();
    n_chk++; if ({rec, warn, irq_warn} !== {8'd10, 1'b1, IRQ_ON}) begin
      n_fail++; $display("FAIL warn.rise got rec=%0d warn=%b irq=%b want 10/1/%b", rec, warn, irq_warn, IRQ_ON); end
    idle();
    step();
    n_chk++; if ({warn, irq_warn} !== 2'b10) begin
      n_fail++; $display("FAIL warn.hold got warn=%b irq=%b want 1/0", warn, irq_warn); end
    init_mode = 1; ewl_wr = 1; ewl_wdata = 0;
    step();
    n_chk++; if ({ewl, warn} !== {8'd96, 1'b0}) begin
      n_fail++; $display("FAIL warn.guard got ewl=%0d warn=%b want 96/0", ewl, warn); end
    init_mode = 0; ewl_wdata = 20;
    step();
    n_chk++; if (ewl !== 8'd96) begin n_fail++; $display("FAIL warn.no_init got %0d want 96", ewl); end
    idle();
    init_mode = 1; cnt_wr = 1; rec_wdata = 250;
    step();
    idle();
    bit_en = 1; err = 1; ko_error = 2;
    repeat (2) step();
    n_chk++; if (rec !== 8'd255) begin n_fail++; $display("FAIL warn.rec_sat got %0d want 255", rec); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    init_mode = 1; cnt_wr = 1; tec_wdata = 250; ewl_wr = 1; ewl_wdata = 20;
    step();
    idle();
    bit_en = 1; err = 1; ko_error = 4;
    step();
    idle();
    step();
    bit_en = 1; ebf = 1;
    repeat (50) step();
    n_chk++; if (recov_cnt !== 8'd50) begin n_fail++; $display("FAIL async_reset.pre got %0d want 50", recov_cnt); end
    #2 reset = 1;
    #1;
    n_chk++; if ({tec, rec, ewl, recov_cnt} !== {8'd0, 8'd0, 8'd96, 8'd0}) begin
      n_fail++; $display("FAIL async_reset.cnt got tec=%0d rec=%0d ewl=%0d recov=%0d want 0/0/96/0",
                         tec, rec, ewl, recov_cnt); end
    n_chk++; if ({error_active, error_passive, busoff, warn, irq_warn, irq_state} !== 6'b100000) begin
      n_fail++; $display("FAIL async_reset.flags got %b want 100000",
                         {error_active, error_passive, busoff, warn, irq_warn, irq_state}); end
    idle();
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit heavy;
    logic [2:0] exp_st;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      heavy = ((i / 400) % 2) == 0;
      idle();
      init_mode = ($urandom_range(15) == 0);
      if (init_mode) begin
        cnt_wr = ($urandom_range(3) == 0);
        tec_wdata = m_boff ? 8'($urandom_range(127)) : 8'($urandom);
        rec_wdata = 8'($urandom);
        ewl_wr = ($urandom_range(3) == 0);
        ewl_wdata = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      end
      bit_en = ($urandom_range(3) != 0);
      err = heavy ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
      ko_error = 3'($urandom_range(7));
      transvalid = 1'($urandom_range(1));
      rec_ack = 1'($urandom_range(1));
      ebf = 1'($urandom_range(1));
      step();
      exp_st = (m_st == 0) ? 3'b100 : ((m_st == 1) ? 3'b010 : 3'b001);
      n_chk++; if (tec !== 8'(m_tec % 256)) begin
        n_fail++; $display("FAIL random.tec cyc %0d got %0d want %0d", i, tec, m_tec % 256); end
      n_chk++; if (rec !== 8'(m_rec)) begin
        n_fail++; $display("FAIL random.rec cyc %0d got %0d want %0d", i, rec, m_rec); end
      n_chk++; if ({error_active, error_passive, busoff} !== exp_st) begin
        n_fail++; $display("FAIL random.state cyc %0d got %b want %b", i, {error_active, error_passive, busoff}, exp_st); end
      n_chk++; if ({ewl, recov_cnt} !== {8'(m_ewl), 8'(m_recov)}) begin
        n_fail++; $display("FAIL random.ewl_recov cyc %0d got %0d/%0d want %0d/%0d", i, ewl, recov_cnt, m_ewl, m_recov); end
      n_chk++; if ({warn, irq_warn, irq_state} !== {m_warn, m_irq_w, m_irq_s}) begin
        n_fail++; $display("FAIL random.warn_irq cyc %0d got %b want %b", i,
                           {warn, irq_warn, irq_state}, {m_warn, m_irq_w, m_irq_s}); end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    test_reset();
    test_tec_passive();
    test_rec_ack();
    test_passive_ack();
    test_busoff();
    test_warn();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
